ex_muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit in the EX stage, fed by the ID/EX pipeline register.

---
 rtl/ex_muldiv_unit.sv | 170 +++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit -- iterative RV32M multiply/divide unit for the EX stage.
//
// Takes one M-extension op from ID/EX and holds `stall` high until the result
// is ready. MUL* use a radix-2 shift-add over operand magnitudes. DIV*/REM* use
// restoring shift-subtract over operand magnitudes. Signs are applied when the
// result is produced. Divide-by-zero and signed overflow take a one-cycle fast
// path that skips BUSY.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   valid_in        ID/EX holds an M op
//   op              funct3 (0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU)
//   rs1_data/rs2_data operands A / B
//   rd_in           destination register of the incoming op
//   flush           abort any in-flight op and return to IDLE
//   stall           freeze ID/EX and earlier stages (combinational)
//   result_valid    one-cycle pulse, result/rd_out valid
//   result, rd_out  registered result and its rd, held until the next completion
module ex_muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_in,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd_in,
   input  logic            flush,
   output logic            stall,
   output logic            result_valid,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out
);
   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state;
   logic [CW-1:0]   count;
   logic [2:0]      op_q;
   logic [4:0]      rd_q;
   logic            neg_q;     // product / quotient sign
   logic            neg_r_q;   // remainder sign (follows dividend)
   // hi: product upper half / partial remainder
   // lo: multiplier bits / dividend bits shifting into the quotient
   // m : multiplicand / divisor magnitude
   logic [XLEN-1:0] hi, lo, m;

   // ---------------- acceptance decode ----------------
   logic            a_signed, b_signed, a_neg, b_neg;
   logic [XLEN-1:0] a_abs, b_abs, fast_res;
   logic            div_zero, div_ovf, fast;

   always_comb begin
      a_signed = (op == 3'd1) | (op == 3'd2) | (op == 3'd4) | (op == 3'd6);
      b_signed = (op == 3'd1) | (op == 3'd4) | (op == 3'd6);
      a_neg    = a_signed & rs1_data[XLEN-1];
      b_neg    = b_signed & rs2_data[XLEN-1];
      a_abs    = a_neg ? -rs1_data : rs1_data;
      b_abs    = b_neg ? -rs2_data : rs2_data;
      div_zero = op[2] & (rs2_data == '0);
      // Only the signed divides (op[0]==0) can overflow.
      div_ovf  = op[2] & ~op[0] & (rs1_data == SMIN) & (rs2_data == '1);
      fast     = div_zero | div_ovf;
      // op[1] selects REM/REMU within the divide group.
      if (div_zero) fast_res = op[1] ? rs1_data : '1;
      else          fast_res = op[1] ? '0 : SMIN;
   end

   // ---------------- one iteration ----------------
   logic [XLEN:0]   mul_sum, div_t, div_d;
   logic            ge;
   logic [XLEN-1:0] hi_nx, lo_nx;

   always_comb begin
      mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
      div_t   = {hi, lo[XLEN-1]};
      div_d   = div_t - {1'b0, m};
      // The partial remainder is always below the divisor, so the borrow bit
      // alone tells whether the trial subtraction fits.
      ge      = ~div_d[XLEN];
      if (op_q[2]) begin
         hi_nx = ge ? div_d[XLEN-1:0] : div_t[XLEN-1:0];
         lo_nx = {lo[XLEN-2:0], ge};
      end else begin
         hi_nx = mul_sum[XLEN:1];
         lo_nx = {mul_sum[0], lo[XLEN-1:1]};
      end
   end

   // ---------------- final sign fix-up ----------------
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0]   quo, rem, fin;

   always_comb begin
      prod   = {hi_nx, lo_nx};
      prod_s = neg_q ? -prod : prod;
      quo    = neg_q ? -lo_nx : lo_nx;
      rem    = neg_r_q ? -hi_nx : hi_nx;
      case (op_q)
         3'd0:             fin = prod_s[XLEN-1:0];
         3'd1, 3'd2, 3'd3: fin = prod_s[2*XLEN-1:XLEN];
         3'd4, 3'd5:       fin = quo;
         default:          fin = rem;
      endcase
   end

   assign stall = valid_in & (state != DONE) & ~rst & ~flush;

   // ---------------- FSM + datapath ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         count        <= '0;
         result       <= '0;
         rd_out       <= '0;
         result_valid <= 1'b0;
         op_q         <= '0;
         rd_q         <= '0;
         neg_q        <= 1'b0;
         neg_r_q      <= 1'b0;
         hi           <= '0;
         lo           <= '0;
         m            <= '0;
      end else begin
         result_valid <= 1'b0;
         if (flush) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: if (valid_in) begin
                  op_q    <= op;
                  rd_q    <= rd_in;
                  neg_q   <= a_neg ^ b_neg;
                  neg_r_q <= a_neg;
                  count   <= '0;
                  hi      <= '0;
                  // Multiply shifts B out of lo while adding A. Divide shifts
                  // A out of lo against divisor B.
                  m       <= op[2] ? b_abs : a_abs;
                  lo      <= op[2] ? a_abs : b_abs;
                  if (fast) begin
                     state        <= DONE;
                     result       <= fast_res;
                     rd_out       <= rd_in;
                     result_valid <= 1'b1;
                  end else begin
                     state <= BUSY;
                  end
               end
               BUSY: begin
                  hi    <= hi_nx;
                  lo    <= lo_nx;
                  count <= count + 1'b1;
                  if (count == CW'(XLEN-1)) begin
                     state        <= DONE;
                     result       <= fin;
                     rd_out       <= rd_q;
                     result_valid <= 1'b1;
                  end
               end
               DONE:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;
   logic        clk = 1'b0;
   logic        rst, valid_in, flush;
   logic [2:0]  op;
   logic [31:0] rs1_data, rs2_data;
   logic [4:0]  rd_in;
   logic        stall, result_valid;
   logic [31:0] result;
   logic [4:0]  rd_out;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   int last_issue, last_done;

   ex_muldiv_unit #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .op(op),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in), .flush(flush),
      .stall(stall), .result_valid(result_valid), .result(result), .rd_out(rd_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference: plain 64-bit arithmetic plus the RISC-V corner-case rules.
   function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      int          ia, ib;
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      logic        ovf;
      ia = a; ib = b; sa = ia; sb = ib;
      ua = {32'b0, a}; ub = {32'b0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      ref_res = '0;
      case (o)
         3'd0: begin p = ua * ub; ref_res = p[31:0];  end
         3'd1: begin p = sa * sb; ref_res = p[63:32]; end
         3'd2: begin p = sa * ub; ref_res = p[63:32]; end
         3'd3: begin p = ua * ub; ref_res = p[63:32]; end
         3'd4: if (b == 0) ref_res = 32'hFFFF_FFFF; else if (ovf) ref_res = a; else ref_res = ia / ib;
         3'd5: if (b == 0) ref_res = 32'hFFFF_FFFF; else ref_res = a / b;
         3'd6: if (b == 0) ref_res = a; else if (ovf) ref_res = 0; else ref_res = ia % ib;
         default: if (b == 0) ref_res = a; else ref_res = a % b;
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // Issues one op at the next negedge (cycle T) and follows it cycle by cycle.
   // abort_kind: 0 none, 1 flush at T+abort_at, 2 rst at T+abort_at.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp,
                         input int abort_kind, input int abort_at);
      bit fast;
      int lat;
      fast = o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      lat  = fast ? 1 : 33;
      @(negedge clk);
      flush = 1'b0; valid_in = 1'b1;
      op = o; rs1_data = a; rs2_data = b; rd_in = rd;
      last_issue = cyc;
      #1 chk("stall_T", 32'(stall), 1);
      for (int n = 1; n <= lat; n++) begin
         @(negedge clk);
         if (abort_kind == 1 && n == abort_at) begin
            flush = 1'b1;
            #1 chk("flush_stall", 32'(stall), 0);
            chk("flush_rv", 32'(result_valid), 0);
            return;
         end
         if (abort_kind == 2 && n == abort_at) begin
            rst = 1'b1;
            #1 chk("rst_stall", 32'(stall), 0);
            @(negedge clk);
            chk("rst_result", result, 0);
            chk("rst_rd", 32'(rd_out), 0);
            chk("rst_rv", 32'(result_valid), 0);
            rst = 1'b0; valid_in = 1'b0;
            #1 chk("rst_stall_after", 32'(stall), 0);
            return;
         end
         if (n < lat) begin
            chk("busy_stall", 32'(stall), 1);
            chk("busy_rv", 32'(result_valid), 0);
            // Operands must already be latched; scramble what ID/EX shows.
            if (n == 3) begin
               op = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
            end
         end else begin
            last_done = cyc;
            chk("done_rv", 32'(result_valid), 1);
            chk("done_stall", 32'(stall), 0);
            chk($sformatf("result op%0d %h,%h", o, a, b), result, exp);
            chk("rd_out", 32'(rd_out), 32'(rd));
         end
      end
      valid_in = 1'b0;
   endtask

   initial begin
      logic [2:0]  o;
      logic [31:0] a, b;
      logic [4:0]  r;
      int          t0;

      rst = 1'b1; valid_in = 1'b1; flush = 1'b0;
      op = 3'd0; rs1_data = 32'd3; rs2_data = 32'd4; rd_in = 5'd9;
      @(negedge clk); @(negedge clk);
      chk("reset_stall", 32'(stall), 0);
      chk("reset_rv", 32'(result_valid), 0);
      chk("reset_result", result, 0);
      chk("reset_rd", 32'(rd_out), 0);
      rst = 1'b0; valid_in = 1'b0;

      // Directed values
      run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 0, 0);
      chk("mul_latency", 32'(last_done - last_issue), 33);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 0, 0);
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, 0, 0);
      run_op(3'd2, 32'hFFFF_FFFF, 32'd2,         5'd3, 32'hFFFF_FFFF, 0, 0);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd4, 32'hFFFF_FFFD, 0, 0);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd6, 32'hFFFF_FFFF, 0, 0);
      run_op(3'd5, 32'd100, 32'd7,               5'd7, 32'd14, 0, 0);
      run_op(3'd7, 32'd100, 32'd7,               5'd8, 32'd2, 0, 0);
      run_op(3'd5, 32'd5, 32'd0,                 5'd10, 32'hFFFF_FFFF, 0, 0);
      chk("fast_latency", 32'(last_done - last_issue), 1);
      run_op(3'd6, 32'd5, 32'd0,                 5'd11, 32'd5, 0, 0);
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 0, 0);
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0, 0, 0);

      // Outputs hold while idle
      repeat (3) @(negedge clk);
      chk("hold_result", result, 0);
      chk("hold_rd", 32'(rd_out), 13);
      chk("hold_rv", 32'(result_valid), 0);

      // Flush mid-DIV, then a MUL right behind it
      run_op(3'd4, 32'd1000, 32'd3, 5'd14, 32'd333, 1, 10);
      t0 = last_issue;
      run_op(3'd0, 32'd6, 32'd7, 5'd15, 32'd42, 0, 0);
      chk("flush_then_mul_T", 32'(last_done - t0), 44);

      // Reset mid-MUL
      run_op(3'd0, 32'd9, 32'd9, 5'd16, 32'd81, 2, 5);

      // Back-to-back MULs
      run_op(3'd0, 32'd11, 32'd12, 5'd17, 32'd132, 0, 0);
      t0 = last_issue;
      chk("b2b_first", 32'(last_done - t0), 33);
      run_op(3'd0, 32'hFFFF_FFFF, 32'd5, 5'd18, 32'hFFFF_FFFB, 0, 0);
      chk("b2b_second", 32'(last_done - t0), 67);

      // Randomized ops against the reference
      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom_range(0, 7));
         a = pick();
         b = pick();
         r = 5'($urandom);
         run_op(o, a, b, r, ref_res(o, a, b), 0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
